serial_word_deserializer: RTL and testbench

//  Receive side of the team's bit-serial word link: collects WIDTH bits from a one-bit

---
 rtl/serial_word_deserializer.sv | 99 +++++++++
 tb/tb_serial_word_deserializer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_word_deserializer.sv
// Bit-serial to parallel word receiver: gathers WIDTH strobed bits into a word and
// presents it through a valid/ready output register with sticky overrun on drop.
module serial_word_deserializer #(
    parameter int  WIDTH     = 32,
    parameter bit  LSB_FIRST = 1'b1,
    localparam int CW        = $clog2(WIDTH + 1),
    localparam int IW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             d_i,
    input  logic             d_valid_i,
    output logic [WIDTH-1:0] word_out_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic             busy_o,
    output logic [CW-1:0]    bit_count_o,
    output logic             overrun_o
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic             last_bit;
    logic [IW-1:0]    bit_pos;

    assign last_bit = (count_q == CW'(WIDTH - 1));
    assign bit_pos  = LSB_FIRST ? count_q[IW-1:0] : IW'(WIDTH - 1) - count_q[IW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            count_q   <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            shift_q   <= shift_d;
            count_q   <= count_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = SHIFT;
            SHIFT:   if (!start_i && d_valid_i && last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        shift_d   = shift_q;
        count_d   = count_q;
        word_d    = word_q;
        valid_d   = valid_q & ~word_ready_i;
        overrun_d = overrun_q;

        if (start_i) begin
            shift_d = '0;
            count_d = '0;
        end else if (state_q == SHIFT && d_valid_i) begin
            shift_d[bit_pos] = d_i;
            if (last_bit) begin
                count_d = '0;
                // A full word only lands if the output slot is empty or draining now.
                if (!valid_q || word_ready_i) begin
                    word_d  = shift_d;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    assign word_out_o   = word_q;
    assign word_valid_o = valid_q;
    assign busy_o       = (state_q == SHIFT);
    assign bit_count_o  = count_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Scoreboard bench: LSB-first and MSB-first instances share one serial stream; a
// monitor pops expected words whenever either instance hands a word to the consumer.
module tb_serial_word_deserializer;

    logic        clk = 1'b0;
    logic        reset, start, d, d_valid, word_ready;
    logic [31:0] word_l, word_m;
    logic        valid_l, valid_m, busy_l, busy_m, ovr_l, ovr_m;
    logic [5:0]  cnt_l, cnt_m;

    int errors = 0;
    int checks = 0;
    logic [31:0] q_l[$];
    logic [31:0] q_m[$];

    always #5 clk = ~clk;

    serial_word_deserializer #(.WIDTH(32), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .reset(reset), .start_i(start), .d_i(d), .d_valid_i(d_valid),
        .word_out_o(word_l), .word_valid_o(valid_l), .word_ready_i(word_ready),
        .busy_o(busy_l), .bit_count_o(cnt_l), .overrun_o(ovr_l)
    );

    serial_word_deserializer #(.WIDTH(32), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .start_i(start), .d_i(d), .d_valid_i(d_valid),
        .word_out_o(word_m), .word_valid_o(valid_m), .word_ready_i(word_ready),
        .busy_o(busy_m), .bit_count_o(cnt_m), .overrun_o(ovr_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a word is consumed at the edge following a cycle with valid & ready.
    always @(negedge clk) begin
        if (valid_l && word_ready) begin
            if (q_l.size() == 0) check("lsb_unexpected_word", word_l, 32'hxxxx_xxxx);
            else check("lsb_word", word_l, q_l.pop_front());
        end
        if (valid_m && word_ready) begin
            if (q_m.size() == 0) check("msb_unexpected_word", word_m, 32'hxxxx_xxxx);
            else check("msb_word", word_m, q_m.pop_front());
        end
    end

    task automatic do_start();
        start = 1'b1; d_valid = 1'b1; d = 1'b1;   // d must be ignored in the start cycle
        tick();
        start = 1'b0; d_valid = 1'b0;
        check("busy_after_start", {31'd0, busy_l}, 32'd1);
        check("count_after_start", {26'd0, cnt_l}, 32'd0);
    endtask

    // Sends n bits of w, first bit = w[0]; optional idle gaps before each bit.
    task automatic send_bits(input logic [31:0] w, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                d_valid = 1'b0; d = ~w[i];
                tick();
                check("gap_busy", {31'd0, busy_l}, 32'd1);
                check("gap_count", {26'd0, cnt_l}, i);
            end
            d_valid = 1'b1; d = w[i];
            tick();
        end
        d_valid = 1'b0;
    endtask

    task automatic frame(input logic [31:0] w, input logic [31:0] exp_m, input int gap,
                         input bit expect_out);
        do_start();
        if (expect_out) begin
            q_l.push_back(w);
            q_m.push_back(exp_m);
        end
        send_bits(w, 32, gap);
        check("busy_after_frame", {31'd0, busy_l, busy_m}, 32'd0);
        check("count_after_frame", {20'd0, cnt_l, cnt_m}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; d = 1'b0; d_valid = 1'b0; word_ready = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_word", word_l, 32'd0);
        check("reset_flags", {28'd0, valid_l, busy_l, ovr_l, valid_m}, 32'd0);
        check("reset_count", {26'd0, cnt_l}, 32'd0);

        // d_valid in IDLE must not capture anything
        d_valid = 1'b1; d = 1'b1;
        tick(); tick();
        d_valid = 1'b0;
        check("idle_ignores_d", {25'd0, busy_l, cnt_l}, 32'd0);

        // 1 and 2: 548126 LSB first, both bit orders
        frame(32'h0008_5D1E, 32'h78BA_1000, 0, 1'b1);
        check("t1_valid_latency", {30'd0, valid_l, valid_m}, 32'd3);
        tick();
        check("t1_valid_drops", {30'd0, valid_l, valid_m}, 32'd0);

        // 3: gaps of 3 idle cycles before every bit
        frame(32'h0008_5D1E, 32'h78BA_1000, 3, 1'b1);
        tick();

        // 4: consumer stalled across two frames
        word_ready = 1'b0;
        frame(32'h0000_FFFF, 32'hFFFF_0000, 0, 1'b1);
        check("t4_no_overrun_yet", {31'd0, ovr_l}, 32'd0);
        frame(32'h0000_0001, 32'h8000_0000, 0, 1'b0);
        check("t4_overrun", {30'd0, ovr_l, ovr_m}, 32'd3);
        check("t4_word_held", word_l, 32'h0000_FFFF);
        check("t4_word_held_msb", word_m, 32'hFFFF_0000);
        check("t4_valid_held", {31'd0, valid_l}, 32'd1);
        word_ready = 1'b1;
        tick();
        check("t4_valid_drops", {31'd0, valid_l}, 32'd0);
        check("t4_overrun_sticky", {31'd0, ovr_l}, 32'd1);

        // 5: restart mid-frame
        do_start();
        send_bits(32'h0000_03FF, 10, 0);
        check("t5_count_before_restart", {26'd0, cnt_l}, 32'd10);
        frame(32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 1'b1);
        tick(); tick();

        // 6: reset aborts a partial frame
        do_start();
        send_bits(32'hFFFF_FFFF, 20, 0);
        check("t6_count_before_reset", {26'd0, cnt_l}, 32'd20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_reset_flags", {29'd0, busy_l, valid_l, ovr_l}, 32'd0);
        check("t6_reset_count", {26'd0, cnt_l}, 32'd0);
        d_valid = 1'b1; d = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        d_valid = 1'b0;
        check("t6_no_word", {31'd0, valid_l}, 32'd0);
        tick();

        check("scoreboard_lsb_drained", q_l.size(), 32'd0);
        check("scoreboard_msb_drained", q_m.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
